// File: rtl/meas_bcd_formatter.sv
// ---------------------------------------------------------------------------
// meas_bcd_formatter: samples freq/amp and converts both to 5-digit BCD by
// sequential double-dabble. Optional macro: AMP_PEAK_HOLD_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module meas_bcd_formatter #(
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] freq,
  input  logic [15:0] amp,
  input  logic        update_req,
  output logic [19:0] freq_bcd,
  output logic [19:0] amp_bcd,
  output logic        bcd_valid,
  output logic        busy
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_F = 2'd1,
    SHIFT_A = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          pending_q, pending_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   fbin_q, fbin_d, abin_q, abin_d;
  logic [19:0]   fscr_q, fscr_d, ascr_q, ascr_d;
  logic [19:0]   freq_bcd_q, freq_bcd_d, amp_bcd_q, amp_bcd_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic          w_tick, w_trig, w_capture;
  logic [15:0]   w_amp_cap;
  logic [19:0]   w_ffix, w_afix;

  // Add 3 to every nibble >= 5 before the shift.
  function automatic logic [19:0] dd_fix(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_tick    = (cnt_q == C_CNT_LAST);
  assign w_trig    = w_tick | update_req | pending_q;
  assign w_capture = (state_q == IDLE) && w_trig;
  assign w_ffix    = dd_fix(fscr_q);
  assign w_afix    = dd_fix(ascr_q);

`ifdef AMP_PEAK_HOLD_EN
  logic [15:0] peak_q;

  assign w_amp_cap = (peak_q > amp) ? peak_q : amp;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= w_capture ? 16'd0 : w_amp_cap;
    end
  end
`else
  assign w_amp_cap = amp;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    bit_d       = bit_q;
    fbin_d      = fbin_q;
    abin_d      = abin_q;
    fscr_d      = fscr_q;
    ascr_d      = ascr_q;
    freq_bcd_d  = freq_bcd_q;
    amp_bcd_d   = amp_bcd_q;
    bcd_valid_d = 1'b0;

    // Events arriving during a conversion collapse into one deferred capture.
    if (state_q != IDLE && (w_tick || update_req)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (w_trig) begin
          fbin_d    = freq;
          abin_d    = w_amp_cap;
          fscr_d    = '0;
          ascr_d    = '0;
          bit_d     = '0;
          pending_d = 1'b0;
          state_d   = SHIFT_F;
        end
      end
      SHIFT_F: begin
        {fscr_d, fbin_d} = {w_ffix[18:0], fbin_q, 1'b0};
        bit_d            = bit_q + 4'd1;
        if (bit_q == 4'd15) state_d = SHIFT_A;
      end
      SHIFT_A: begin
        {ascr_d, abin_d} = {w_afix[18:0], abin_q, 1'b0};
        bit_d            = bit_q + 4'd1;
        if (bit_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        freq_bcd_d  = fscr_q;
        amp_bcd_d   = ascr_q;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      bit_q       <= '0;
      fbin_q      <= '0;
      abin_q      <= '0;
      fscr_q      <= '0;
      ascr_q      <= '0;
      freq_bcd_q  <= '0;
      amp_bcd_q   <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= w_tick ? '0 : cnt_q + CW'(1);
      pending_q   <= pending_d;
      bit_q       <= bit_d;
      fbin_q      <= fbin_d;
      abin_q      <= abin_d;
      fscr_q      <= fscr_d;
      ascr_q      <= ascr_d;
      freq_bcd_q  <= freq_bcd_d;
      amp_bcd_q   <= amp_bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign freq_bcd  = freq_bcd_q;
  assign amp_bcd   = amp_bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
